// File: rtl/cr_iu_gated_reg_wr_ctrl.sv
// Write-port sequencer in front of a gated-clock register: one-entry hold stage feeding the registered write stage.
// Optional: CR_IU_WR_CTRL_REDUNDANT_SKIP_EN suppresses write_en when the computed value equals the current one.
module cr_iu_gated_reg_wr_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             cp0_yy_clk_en,
  input  logic             req_vld,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_rdy,
  input  logic [WIDTH-1:0] reg_dout,
  output logic             write_en,
  output logic [WIDTH-1:0] write_data,
  output logic             err_op
);

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_SET = 2'b01;
  localparam logic [1:0] OP_CLR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  logic             hold_vld;
  logic [1:0]       hold_op;
  logic [WIDTH-1:0] hold_data;

  logic             wr_retire;
  logic             w_free;
  logic             accept;
  logic             advance;
  logic             do_write;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] new_val;

  // The register only captures when its gate is enabled, so W drains only then.
  assign wr_retire = write_en & cp0_yy_clk_en;
  assign w_free    = !write_en | wr_retire;
  assign req_rdy   = !hold_vld | w_free;
  assign accept    = req_vld & req_rdy;
  assign advance   = hold_vld & w_free;

  // An in-flight write is newer than the register contents.
  assign base = write_en ? write_data : reg_dout;

  always_comb begin
    new_val = base;
    case (hold_op)
      OP_WR:   new_val = hold_data;
      OP_SET:  new_val = base | hold_data;
      OP_CLR:  new_val = base & ~hold_data;
      default: new_val = base;
    endcase
  end

`ifdef CR_IU_WR_CTRL_REDUNDANT_SKIP_EN
  assign do_write = (hold_op != OP_RSV) && (new_val != base);
`else
  assign do_write = (hold_op != OP_RSV);
`endif

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      hold_vld  <= 1'b0;
      hold_op   <= OP_WR;
      hold_data <= '0;
    end else if (accept) begin
      hold_vld  <= 1'b1;
      hold_op   <= req_op;
      hold_data <= req_data;
    end else if (advance) begin
      hold_vld  <= 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      write_en   <= 1'b0;
      write_data <= '0;
      err_op     <= 1'b0;
    end else begin
      err_op <= 1'b0;
      if (advance) begin
        write_en <= do_write;
        err_op   <= (hold_op == OP_RSV);
        if (do_write) write_data <= new_val;
      end else if (wr_retire) begin
        write_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cr_iu_gated_reg_wr_ctrl.sv
// Bench for cr_iu_gated_reg_wr_ctrl: models the gated register and scoreboards every retired write.
module tb_cr_iu_gated_reg_wr_ctrl;
  localparam int W = 32;
`ifdef CR_IU_WR_CTRL_REDUNDANT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ce_dir = 1'b1;
  logic         rnd_en = 1'b0;
  logic         rnd_ce = 1'b1;
  logic         ce;
  logic         req_vld = 1'b0;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_data = '0;
  logic         req_rdy, write_en, err_op;
  logic [W-1:0] write_data;
  logic [W-1:0] reg_q = '0;

  int           n_chk = 0;
  int           n_fail = 0;
  int           err_exp = 0;
  int           err_seen = 0;
  int           waited;
  logic [W-1:0] model = '0;
  logic [W-1:0] saved;
  logic [W-1:0] exp_q[$];

  assign ce = rnd_en ? rnd_ce : ce_dir;

  cr_iu_gated_reg_wr_ctrl #(.WIDTH(W)) dut (
    .forever_cpuclk(clk),
    .cpurst        (rst),
    .cp0_yy_clk_en (ce),
    .req_vld       (req_vld),
    .req_op        (req_op),
    .req_data      (req_data),
    .req_rdy       (req_rdy),
    .reg_dout      (reg_q),
    .write_en      (write_en),
    .write_data    (write_data),
    .err_op        (err_op)
  );

  always #5 clk = ~clk;

  // Gated register: no reset, captures only while enabled.
  always @(posedge clk) if (write_en && ce) reg_q <= write_data;

  initial forever begin
    @(posedge clk);
    #2;
    rnd_ce = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (err_op) err_seen++;
      if (write_en && ce) begin
        if (exp_q.size() == 0) chk("sb_unexpected_write", 32'(exp_q.size()), 32'd1);
        else chk("sb_wdata", write_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [W-1:0] d, output int wt);
    logic [W-1:0] nv;
    wt = 0;
    req_vld = 1'b1;
    req_op = op;
    req_data = d;
    #1;
    while (!req_rdy && wt < 60) begin
      @(posedge clk);
      #3;
      wt++;
    end
    if (!req_rdy) begin
      chk("send_timeout", 32'(wt), 32'd0);
      req_vld = 1'b0;
    end else begin
      @(posedge clk);
      case (op)
        2'b00:   nv = d;
        2'b01:   nv = model | d;
        2'b10:   nv = model & ~d;
        default: nv = model;
      endcase
      if (op == 2'b11) err_exp++;
      else if (!(SKIP && nv == model)) exp_q.push_back(nv);
      model = nv;
      #2;
      req_vld = 1'b0;
    end
  endtask

  initial begin
    tick(3);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_write_data", write_data, 32'h0);
    chk("rst_err_op", 32'(err_op), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_req_rdy", 32'(req_rdy), 32'd1);
    tick(1);

    // single write, latency and pulse width
    send(2'b00, 32'h0000_00F0, waited);
    chk("t1_wait", 32'(waited), 32'd0);
    chk("t1_we_hold", 32'(write_en), 32'd0);
    tick(1);
    chk("t1_we", 32'(write_en), 32'd1);
    chk("t1_wdata", write_data, 32'h0000_00F0);
    chk("t1_reg_before", reg_q, 32'h0);
    tick(1);
    chk("t1_we_off", 32'(write_en), 32'd0);
    chk("t1_reg", reg_q, 32'h0000_00F0);

    // back-to-back RMW relies on forwarding
    send(2'b01, 32'h0000_000F, waited);
    send(2'b10, 32'h0000_0081, waited);
    chk("t2_wait", 32'(waited), 32'd0);
    chk("t2_wdata0", write_data, 32'h0000_00FF);
    tick(1);
    chk("t2_we1", 32'(write_en), 32'd1);
    chk("t2_wdata1", write_data, 32'h0000_007E);
    tick(1);
    chk("t2_reg", reg_q, 32'h0000_007E);

    // stall with clock enable low
    send(2'b00, 32'h11, waited);
    ce_dir = 1'b0;
    send(2'b00, 32'h22, waited);
    chk("t3_second_acc", 32'(waited), 32'd0);
    req_vld = 1'b1;
    req_op = 2'b00;
    req_data = 32'h33;
    #1;
    repeat (3) begin
      chk("t3_rdy_low", 32'(req_rdy), 32'd0);
      chk("t3_we_stable", 32'(write_en), 32'd1);
      chk("t3_wdata_stable", write_data, 32'h11);
      chk("t3_reg_stable", reg_q, 32'h7E);
      tick(1);
    end
    ce_dir = 1'b1;
    send(2'b00, 32'h33, waited);
    tick(3);
    chk("t3_reg", reg_q, 32'h33);

    // reserved op
    saved = reg_q;
    send(2'b11, 32'h1234, waited);
    send(2'b00, 32'h55, waited);
    chk("t4_next_acc", 32'(waited), 32'd0);
    chk("t4_err", 32'(err_op), 32'd1);
    chk("t4_no_we", 32'(write_en), 32'd0);
    chk("t4_reg", reg_q, saved);
    tick(1);
    chk("t4_err_off", 32'(err_op), 32'd0);
    chk("t4_we55", 32'(write_en), 32'd1);
    chk("t4_wdata55", write_data, 32'h55);
    tick(2);

    // reset with both stages full
    saved = reg_q;
    ce_dir = 1'b0;
    send(2'b00, 32'h66, waited);
    send(2'b00, 32'h77, waited);
    chk("t5_full", 32'(req_rdy), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_we", 32'(write_en), 32'd0);
    chk("t5_rdy", 32'(req_rdy), 32'd1);
    chk("t5_err", 32'(err_op), 32'd0);
    exp_q.delete();
    model = saved;
    tick(1);
    rst = 1'b0;
    ce_dir = 1'b1;
    tick(3);
    chk("t5_reg", reg_q, saved);

    // redundant set
    send(2'b00, 32'hFF, waited);
    tick(3);
    chk("t6_reg", reg_q, 32'hFF);
    send(2'b01, 32'h01, waited);
    tick(1);
    if (SKIP) begin
      chk("t6_skip_we", 32'(write_en), 32'd0);
      chk("t6_skip_rdy", 32'(req_rdy), 32'd1);
    end else begin
      chk("t6_we", 32'(write_en), 32'd1);
      chk("t6_wdata", write_data, 32'hFF);
    end
    tick(2);

    // random traffic under a toggling clock enable
    rnd_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      send(2'($urandom_range(0, 3)), $urandom, waited);
      if ($urandom_range(0, 2) == 0) tick(1);
    end
    rnd_en = 1'b0;
    ce_dir = 1'b1;
    tick(6);
    chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("end_err_count", 32'(err_seen), 32'(err_exp));
    chk("end_reg", reg_q, model);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
